// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// State encodings and the bit-counter width helper live here.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/half_adder.sv
// Half adder cell: sum and carry of two bits.
// Building block of the serial full-adder cell.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_fa_bit.sv
// Combinational full adder from two half_adder cells.
// Used once by serial_adder for the per-clock bit sum.
module serial_fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (cin),
    .s (s),
    .c (c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, LSB first, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             carry
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t         state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [CW-1:0]  cnt;
  logic           c_reg;
  logic           fa_s;
  logic           fa_co;
  logic [WIDTH-1:0] sum_nxt;

  serial_fa_bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c_reg),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign in_ready = !rst && (state == ST_IDLE);
  assign sum_nxt  = {fa_s, sum_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      cnt       <= '0;
      c_reg     <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_sr  <= a;
            b_sr  <= b;
            c_reg <= 1'b0;
            cnt   <= '0;
            state <= ST_ADD;
          end
        end
        ST_ADD: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_nxt;
          c_reg  <= fa_co;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum       <= sum_nxt;
            carry     <= fa_co;
            out_valid <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
            // c_reg here is the carry into the MSB
            ovf       <= c_reg ^ fa_co;
`endif
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard testbench for serial_adder with directed vectors.
// Define SERIAL_ADDER_OVF_EN to also check ovf.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] sum;
  logic       carry;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .carry     (carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pop and compare on every output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_sum", {24'd0, sum}, {24'd0, e.s});
        chk("sb_carry", {31'd0, carry}, {31'd0, e.c});
`ifdef SERIAL_ADDER_OVF_EN
        chk("sb_ovf", {31'd0, ovf}, {31'd0, e.o});
`endif
      end
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] es, input logic ec,
                      input logic eo, input bit push);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
    chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) begin
      e.s = es;
      e.c = ec;
      e.o = eo;
      sb.push_back(e);
    end
  endtask

  task automatic wait_ov();
    @(negedge clk);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    send(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_ov();

    send(8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (i < 8) chk("add_in_ready", {31'd0, in_ready}, 32'd0);
      chk("latency_valid", {31'd0, out_valid}, (i == 8) ? 32'd1 : 32'd0);
    end

    send(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_ov();
    @(posedge clk);
    #1;
    chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_hs_sum_held", {24'd0, sum}, 32'h00);
    chk("post_hs_carry_held", {31'd0, carry}, 32'd1);

    out_ready = 1'b0;
    send(8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    a = 8'h33;
    b = 8'h44;
    wait_ov();
    for (int i = 0; i < 5; i++) begin
      chk("stall_sum", {24'd0, sum}, 32'hFF);
      chk("stall_carry", {31'd0, carry}, 32'd0);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;

    send(8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_sum", {24'd0, sum}, 32'd0);
    chk("abort_carry", {31'd0, carry}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    send(8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b1);
    wait_ov();

`ifdef SERIAL_ADDER_OVF_EN
    send(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1);
    wait_ov();
`endif

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
